// File: rtl/pipelined_text_memory.sv
// pipelined_text_memory
//   Read-only instruction memory with a request/response handshake. Reads
//   complete LATENCY cycles after acceptance, several may be in flight, and
//   finished reads wait in a small response FIFO until the fetch stage takes
//   them, so backpressure never loses a word.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   req_valid    fetch request present
//   req_ready    request can be accepted this cycle
//   req_address  word address
//   flush        drop every in-flight read and queued response
//   rsp_valid    rsp_data holds the oldest pending response
//   rsp_ready    consumer takes the response this cycle
//   rsp_data     instruction word (zero while rsp_valid is low)
module pipelined_text_memory #(
    parameter int    TEXT_BITS       = 16,
    parameter int    DATA_WIDTH      = 32,
    parameter int    LATENCY         = 2,
    parameter int    MAX_OUTSTANDING = 4,
    parameter string INIT_FILE       = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [TEXT_BITS-3:0]  req_address,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data
);

    localparam int DEPTH = 2 ** (TEXT_BITS - 2);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read pipeline: stage 0 is the registered memory read, the remaining
    // stages only delay it so the word surfaces LATENCY cycles after accept.
    logic [LATENCY-1:0]    pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [LATENCY];

    // Response FIFO for words that arrived while the consumer stalled.
    logic [DATA_WIDTH-1:0] fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      fifo_count, fifo_count_next;
    logic [CNT_W-1:0]      outstanding, outstanding_next;

    logic                  accept, arrive_valid, fifo_empty, pop, push, fifo_pop;
    logic [DATA_WIDTH-1:0] head_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign req_ready    = (outstanding < CNT_W'(MAX_OUTSTANDING)) && !flush;
    assign accept       = req_valid && req_ready;
    assign arrive_valid = pipe_valid[LATENCY-1];
    assign fifo_empty   = (fifo_count == '0);

    // Queued words are older than the one arriving, so the FIFO head wins;
    // an arriving word is presented directly when nothing is queued.
    assign rsp_valid = !fifo_empty || arrive_valid;
    assign head_data = fifo_empty ? pipe_data[LATENCY-1] : fifo[rd_ptr];
    assign rsp_data  = rsp_valid ? head_data : '0;

    assign pop      = rsp_valid && rsp_ready;
    assign fifo_pop = pop && !fifo_empty;
    // An arriving word consumed in the same cycle bypasses the FIFO.
    assign push     = arrive_valid && !(pop && fifo_empty);

    always_comb begin
        fifo_count_next = fifo_count;
        unique case ({push, fifo_pop})
            2'b10:   fifo_count_next = fifo_count + CNT_W'(1);
            2'b01:   fifo_count_next = fifo_count - CNT_W'(1);
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_comb begin
        outstanding_next = outstanding;
        unique case ({accept, pop})
            2'b10:   outstanding_next = outstanding + CNT_W'(1);
            2'b01:   outstanding_next = outstanding - CNT_W'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else if (flush) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    // Data paths carry no reset; their valid bits qualify them.
    always_ff @(posedge clock) begin
        if (accept) pipe_data[0] <= mem[req_address];
        for (int i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
        if (push && !flush) fifo[wr_ptr] <= pipe_data[LATENCY-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else begin
            if (push)     wr_ptr <= next_ptr(wr_ptr);
            if (fifo_pop) rd_ptr <= next_ptr(rd_ptr);
            fifo_count  <= fifo_count_next;
            outstanding <= outstanding_next;
        end
    end

    a_outstanding_max : assert property (@(posedge clock) disable iff (reset)
        outstanding <= CNT_W'(MAX_OUTSTANDING));
    a_no_underflow : assert property (@(posedge clock) disable iff (reset)
        pop |-> (outstanding != '0));
    a_fifo_bounded : assert property (@(posedge clock) disable iff (reset)
        fifo_count <= outstanding);

endmodule

// File: tb/tb_pipelined_text_memory.sv
module tb_pipelined_text_memory;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_address = '0;
    logic        flush = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_w [2];
    logic        rsp_valid_w [2];
    logic [31:0] rsp_data_w  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        v = 32'(i + 1) * 32'h9E3779B9;
        return (i == 16) ? 32'h00A00093 : (v ^ 32'(i));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instance 0: LATENCY=2, MAX_OUTSTANDING=4. Instance 1: LATENCY=1, MAX_OUTSTANDING=1.
    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int L = (g == 0) ? 2 : 1;
        localparam int M = (g == 0) ? 4 : 1;

        pipelined_text_memory #(
            .TEXT_BITS(10), .DATA_WIDTH(32), .LATENCY(L), .MAX_OUTSTANDING(M), .INIT_FILE("")
        ) dut (
            .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w[g]),
            .req_address(req_address), .flush(flush), .rsp_valid(rsp_valid_w[g]),
            .rsp_ready(rsp_ready), .rsp_data(rsp_data_w[g])
        );

        initial for (int i = 0; i < 256; i++) dut.mem[i] = pat(i);

        // Model: a queue of accepted reads, each with the cycle it becomes visible.
        logic [31:0] q_data [$];
        int          q_time [$];
        int          cyc = 0;
        int          sz;
        logic        ev;

        always @(posedge clock or posedge reset) begin
            if (reset) begin
                q_data.delete();
                q_time.delete();
            end else begin
                sz = q_data.size();
                ev = (sz > 0) && (q_time[0] <= cyc);
                if (ev && rsp_ready) begin
                    void'(q_data.pop_front());
                    void'(q_time.pop_front());
                end
                if (flush) begin
                    q_data.delete();
                    q_time.delete();
                end else if (req_valid && sz < M) begin
                    q_data.push_back(pat(int'(req_address)));
                    q_time.push_back(cyc + L);
                end
                cyc++;
            end
        end

        always @(negedge clock) begin
            logic        exp_v;
            logic [31:0] exp_d;
            exp_v = (q_data.size() > 0) && (q_time[0] <= cyc);
            exp_d = exp_v ? q_data[0] : 32'h0;
            check($sformatf("cfg%0d rsp_valid", g), 32'(rsp_valid_w[g]), 32'(exp_v));
            check($sformatf("cfg%0d rsp_data", g), rsp_data_w[g], exp_d);
            check($sformatf("cfg%0d req_ready", g), 32'(req_ready_w[g]),
                  32'((q_data.size() < M) && !flush));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset rsp_valid", 32'(rsp_valid_w[0]), 32'h0);
        check("reset rsp_data", rsp_data_w[0], 32'h0);
        check("reset req_ready", 32'(req_ready_w[0]), 32'h1);
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        tick();

        // Single read of 0x10, LATENCY=2
        req_valid = 1'b1; req_address = 8'h10;
        tick();
        req_valid = 1'b0;
        @(negedge clock);
        check("single c+1 valid", 32'(rsp_valid_w[0]), 32'h0);
        tick();
        @(negedge clock);
        check("single c+2 valid", 32'(rsp_valid_w[0]), 32'h1);
        check("single c+2 data", rsp_data_w[0], 32'h00A00093);
        tick();
        @(negedge clock);
        check("single c+3 valid", 32'(rsp_valid_w[0]), 32'h0);
        tick();

        // Back-to-back 0..7 with rsp_ready=1: no bubbles
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 8); req_address = 8'(i);
            @(negedge clock);
            if (i < 8) check("stream req_ready", 32'(req_ready_w[0]), 32'h1);
            if (i >= 2) check("stream data", rsp_data_w[0], pat(i - 2));
            tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: 4 accepts then req_ready drops
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_address = 8'(i);
            @(negedge clock);
            if (i >= 4) check("bp req_ready low", 32'(req_ready_w[0]), 32'h0);
            if (i >= 2) check("bp head stable", rsp_data_w[0], pat(0));
            tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clock);
        check("bp pop cycle ready", 32'(req_ready_w[0]), 32'h0);
        check("bp drain 0", rsp_data_w[0], pat(0));
        for (int i = 1; i < 4; i++) begin
            tick();
            @(negedge clock);
            if (i == 1) check("bp ready after pop", 32'(req_ready_w[0]), 32'h1);
            check("bp drain", rsp_data_w[0], pat(i));
        end
        tick();
        @(negedge clock);
        check("bp drained", 32'(rsp_valid_w[0]), 32'h0);
        tick();

        // Flush with 3 outstanding
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1; req_address = 8'(i);
            tick();
        end
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clock);
        check("flush req_ready", 32'(req_ready_w[0]), 32'h0);
        tick();
        flush = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post flush valid", 32'(rsp_valid_w[0]), 32'h0);
            tick();
        end
        req_valid = 1'b1; req_address = 8'h20;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clock);
        check("post flush data", rsp_data_w[0], pat(32));
        tick();

        // Async reset with 2 entries queued
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_address = 8'd7;
        tick();
        req_address = 8'd8;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clock);
        check("pre reset data", rsp_data_w[0], pat(7));
        #2 reset = 1'b1;
        #1;
        check("async reset valid", 32'(rsp_valid_w[0]), 32'h0);
        check("async reset data", rsp_data_w[0], 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("after reset ready", 32'(req_ready_w[0]), 32'h1);
        tick();
        rsp_ready = 1'b1; req_valid = 1'b1; req_address = 8'd9;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clock);
        check("after reset data", rsp_data_w[0], pat(9));
        repeat (2) tick();

        // LATENCY=1, MAX_OUTSTANDING=1: req_ready alternates
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_address = 8'(40 + i);
            @(negedge clock);
            check("l1 ready alternates", 32'(req_ready_w[1]), 32'((i % 2) == 0));
            if (i % 2 == 1) check("l1 data", rsp_data_w[1], pat(40 + i - 1));
            tick();
        end
        req_valid = 1'b0;
        repeat (2) tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_address = 8'($urandom);
            flush       = ($urandom_range(0, 40) == 0);
            rsp_ready   = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                              : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 500) == 0) begin
                #3 reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end
        req_valid = 1'b0; flush = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
